round_pipe: RTL and testbench
=============================

# round_pipe

Pipelined, parametrised successor to the combinational IEEE-754 rounding stage. It takes an unrounded sign, signed exponent, and wide significand, and returns a rounded significand and exponent plus exception flags. Compared with the combinational rounder it adds:
- valid/ready flow control;
- roundTiesToAway mode;
- overflow saturation to infinity or max-finite;
- underflow signalling;
- a generic incrementer in place of the per-format padder selection.

It sits between the add/sub normaliser and result packing.

## Interface
- `INTn`, 32: unrounded significand width; must satisfy INTn ≥ NSIG+3.
- `NEXP`, 8: exponent field width.
- `NSIG`, 23: stored fraction width; the significand is NSIG+1 bits with the hidden bit.
- Derived constants (not overridable): EMAX = 2^(NEXP-1)-1, EMIN = 1-EMAX.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept an input beat.
- `negIn` in 1: sign.
- `expIn` in NEXP+2 (signed): unbiased exponent of `sigIn[INTn-1]`.
- `sigIn` in INTn: significand, MSB-aligned; the MSB is the hidden-bit position.
- `ra` in NRAS+1: one-hot rounding attribute. Bit indices come from `ieee-754-flags.vh`, which defines NRAS=4 and the indices roundTiesToEven, roundTiesToAway, roundTowardPositive, roundTowardNegative, roundTowardZero.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `negOut` out 1: sign, passed through unchanged.
- `expOut` out NEXP+2 (signed): rounded exponent.
- `sigOut` out NSIG+1: rounded significand.
- `inexact`, `overflow`, `underflow` out 1 each: exception flags.

## Operation
- Stage 1 (align): compute shift d = clamp(EMIN - expIn, 0, NSIG+2).
  - Right-shift `sigIn` by d.
  - Take kept K = top NSIG+1 bits, L = LSB of K, G = next bit, S = OR of all remaining bits, including bits shifted out.
  - Register K, L, G, S, sign, mode, expA = max(expIn, EMIN), and tiny = (expIn < EMIN).
- Stage 2 (round): round-up decision inc, by mode:
  - RNE: G&(L|S).
  - RNA: G.
  - RTP: ~neg&(G|S).
  - RTN: neg&(G|S).
  - RTZ: 0.
- Stage 2 arithmetic: R = K + inc computed at NSIG+2 bits.
  - Carry out: sig = R[NSIG+1:1], exp = expA+1.
  - Subnormal reaching 2^NSIG: sig keeps its hidden bit, exp stays EMIN (promotion to normal).
- inexact = G|S.
- underflow = tiny & inexact (tininess before rounding).
- Overflow when exp > EMAX: overflow=1, inexact=1, and the result depends on mode and sign:
  - RNE, RNA, RTP with positive sign, RTN with negative sign: infinity, i.e. expOut = EMAX+1, sigOut = 1<<NSIG.
  - Otherwise: max finite, i.e. expOut = EMAX, sigOut = all ones.
- Subnormal or zero results: expOut = EMIN, `sigOut[NSIG]`=0. A zero result has sigOut=0 and expOut=EMIN.
- A `ra` value that is not one-hot is treated as RTZ.
- Arithmetic on exponents is signed NEXP+2 bits, which is sufficient because |expIn| ≤ 2^(NEXP+1)-1.

## Timing
- Latency is 2 cycles from input acceptance (in_valid&in_ready) to out_valid, with no bubbles. Throughput is 1 per clock while out_ready=1.
- Stall: stage-2 advance a2 = ~v2 | out_ready. Stage-1 advance a1 = ~v1 | a2. in_ready = a1, which is combinational from out_ready (no skid buffer).
- Output data is held stable while out_valid & ~out_ready.
- Reset (rst_n=0 at a clock edge): all valid bits clear; in_ready=1 in the same cycle as the reset edge.
- Reset values of data outputs: negOut, expOut, sigOut and all flags are 0.
- Reset mid-operation discards in-flight beats with no output.
- Simultaneous events: a stage accepts a new beat in the same cycle its old beat drains.
- No FSM beyond the two valid bits.

## Structure
- The rounding-mode indices, NRAS, and the EMIN/EMAX derivation belong in `ieee-754-flags.vh`. The header is extended with roundTiesToAway.
- One sub-module, `round_decide`: combinational mapping of (ra, neg, L, G, S) to (inc, inexact). It is instantiated in stage 2 and reused by other rounders.

## Test plan
All scenarios use the defaults INTn=32, NEXP=8, NSIG=23.
- RNE, expIn=0, sigIn=32'h80000080 (tie, L=0) → 2 cycles later sigOut=24'h800000, expOut=0, inexact=1. With sigIn=32'h80000180 → sigOut=24'h800002.
- sigIn=32'hFFFFFFFF, expIn=127:
  - RNE → overflow=1, inexact=1, expOut=128, sigOut=24'h800000.
  - RTZ → expOut=127, sigOut=24'hFFFFFF.
  - RTN, negIn=0 → max finite.
- expIn=-127, sigIn=32'h80000000 → expOut=-126, sigOut=24'h400000, all flags 0. With expIn=-150 in RNE → sigOut=0, underflow=1, inexact=1. In RTP with negIn=0 → sigOut=1.
- RNA, expIn=0, sigIn=32'h80000080 → sigOut=24'h800001. The same input in RTZ → 24'h800000, inexact=1.
- Backpressure: stream 8 beats and hold out_ready=0 for 5 cycles mid-stream → in_ready drops once both stages are full; no beat is lost or duplicated; order is preserved; output is stable while stalled.
- Assert rst_n=0 for one cycle with 2 beats in flight → out_valid=0 the next cycle, neither beat emerges, and in_ready=1.

Source files
------------

// File: rtl/round_pipe_pkg.sv
// Shared rounding constants for round_pipe and round_decide.
// Holds rounding-attribute bit indices and exponent range helpers.
package round_pipe_pkg;

    // Number of rounding attributes minus one; ra is NRAS+1 bits wide.
    localparam int NRAS = 4;

    // Bit indices into the one-hot rounding attribute.
    localparam int ROUND_TIES_TO_EVEN      = 0;
    localparam int ROUND_TIES_TO_AWAY      = 1;
    localparam int ROUND_TOWARD_POSITIVE   = 2;
    localparam int ROUND_TOWARD_NEGATIVE   = 3;
    localparam int ROUND_TOWARD_ZERO       = 4;

    function automatic int emax_of(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

    function automatic int emin_of(input int nexp);
        return 1 - emax_of(nexp);
    endfunction

endpackage

// File: rtl/round_decide.sv
// Combinational round-up decision for IEEE-754 rounders.
// Ports: ra (one-hot mode), neg, l/g/s bits -> inc, inexact, ovf_inf.
import round_pipe_pkg::*;

module round_decide (
    input  logic [NRAS:0] ra,
    input  logic          neg,
    input  logic          l,
    input  logic          g,
    input  logic          s,
    output logic          inc,
    output logic          inexact,
    output logic          ovf_inf
);

    logic one_hot;

    // A malformed attribute falls back to truncation.
    assign one_hot = (ra != '0) && ((ra & (ra - 1'b1)) == '0);

    always_comb begin
        inc     = 1'b0;
        ovf_inf = 1'b0;
        inexact = g | s;
        if (one_hot) begin
            unique case (1'b1)
                ra[ROUND_TIES_TO_EVEN]: begin
                    inc     = g & (l | s);
                    ovf_inf = 1'b1;
                end
                ra[ROUND_TIES_TO_AWAY]: begin
                    inc     = g;
                    ovf_inf = 1'b1;
                end
                ra[ROUND_TOWARD_POSITIVE]: begin
                    inc     = ~neg & (g | s);
                    ovf_inf = ~neg;
                end
                ra[ROUND_TOWARD_NEGATIVE]: begin
                    inc     = neg & (g | s);
                    ovf_inf = neg;
                end
                default: begin
                    inc     = 1'b0;
                    ovf_inf = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage pipelined IEEE-754 rounder with valid/ready flow control.
// Ports: in_* beat (negIn/expIn/sigIn/ra), out_* beat (negOut/expOut/sigOut, flags).
import round_pipe_pkg::*;

module round_pipe #(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   negIn,
    input  logic signed [NEXP+1:0] expIn,
    input  logic [INTn-1:0]        sigIn,
    input  logic [NRAS:0]          ra,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   negOut,
    output logic signed [NEXP+1:0] expOut,
    output logic [NSIG:0]          sigOut,
    output logic                   inexact,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int EW   = NEXP + 2;
    localparam int DW   = EW + 1;
    localparam int SW   = $clog2(INTn);
    localparam int DMAX = NSIG + 2;

    localparam logic signed [EW-1:0] EMAX   = EW'(emax_of(NEXP));
    localparam logic signed [EW-1:0] EMIN   = EW'(emin_of(NEXP));
    localparam logic signed [EW-1:0] EINF   = EW'(emax_of(NEXP) + 1);
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [DW-1:0] DMAX_S = DW'(DMAX);

    // Handshake
    logic a1;
    logic a2;

    // Stage 1 state
    logic                 v1_q,    v1_d;
    logic [NSIG:0]        k1_q,    k1_d;
    logic                 g1_q,    g1_d;
    logic                 s1_q,    s1_d;
    logic                 neg1_q,  neg1_d;
    logic [NRAS:0]        ra1_q,   ra1_d;
    logic signed [EW-1:0] exp1_q,  exp1_d;
    logic                 tiny1_q, tiny1_d;

    // Stage 2 (output) state
    logic                 v2_q,   v2_d;
    logic                 neg2_q, neg2_d;
    logic signed [EW-1:0] exp2_q, exp2_d;
    logic [NSIG:0]        sig2_q, sig2_d;
    logic                 inx2_q, inx2_d;
    logic                 ovf2_q, ovf2_d;
    logic                 unf2_q, unf2_d;

    // Stage 1 datapath
    logic signed [DW-1:0] diff;
    logic [SW-1:0]        d;
    logic [INTn-1:0]      shifted;
    logic [INTn-1:0]      lost_mask;
    logic [NSIG:0]        k_a;
    logic                 g_a;
    logic                 s_a;
    logic                 tiny_a;
    logic signed [EW-1:0] exp_a;

    // Stage 2 datapath
    logic                 inc;
    logic                 inx_dec;
    logic                 ovf_inf;
    logic [NSIG+1:0]      r;
    logic [NSIG:0]        sig_r;
    logic signed [EW-1:0] exp_r;
    logic                 inx_r;
    logic                 ovf_r;

    always_comb begin
        a2 = ~v2_q | out_ready;
        a1 = ~v1_q | a2;
    end

    assign in_ready = a1;

    always_comb begin
        diff = {EMIN[EW-1], EMIN} - {expIn[EW-1], expIn};
        if (diff < 0) begin
            d = '0;
        end else if (diff > DMAX_S) begin
            d = SW'(DMAX);
        end else begin
            d = diff[SW-1:0];
        end
        shifted   = sigIn >> d;
        // Bits pushed off the bottom still count toward sticky.
        lost_mask = ~({INTn{1'b1}} << d);
        k_a       = shifted[INTn-1 -: NSIG+1];
        g_a       = shifted[INTn-NSIG-2];
        s_a       = (|shifted[INTn-NSIG-3:0]) | (|(sigIn & lost_mask));
        tiny_a    = expIn < EMIN;
        exp_a     = tiny_a ? EMIN : expIn;
    end

    round_decide u_decide (
        .ra      (ra1_q),
        .neg     (neg1_q),
        .l       (k1_q[0]),
        .g       (g1_q),
        .s       (s1_q),
        .inc     (inc),
        .inexact (inx_dec),
        .ovf_inf (ovf_inf)
    );

    always_comb begin
        r     = {1'b0, k1_q} + {{(NSIG+1){1'b0}}, inc};
        inx_r = inx_dec;
        if (r[NSIG+1]) begin
            sig_r = r[NSIG+1:1];
            exp_r = exp1_q + ONE;
        end else begin
            sig_r = r[NSIG:0];
            exp_r = exp1_q;
        end
        // No hidden bit: subnormal or zero result sits at EMIN.
        if (!sig_r[NSIG]) begin
            exp_r = EMIN;
        end
        ovf_r = exp_r > EMAX;
        if (ovf_r) begin
            inx_r = 1'b1;
            if (ovf_inf) begin
                exp_r = EINF;
                sig_r = {1'b1, {NSIG{1'b0}}};
            end else begin
                exp_r = EMAX;
                sig_r = {(NSIG+1){1'b1}};
            end
        end
    end

    always_comb begin
        v1_d    = v1_q;
        k1_d    = k1_q;
        g1_d    = g1_q;
        s1_d    = s1_q;
        neg1_d  = neg1_q;
        ra1_d   = ra1_q;
        exp1_d  = exp1_q;
        tiny1_d = tiny1_q;
        if (a1) begin
            v1_d = in_valid;
            if (in_valid) begin
                k1_d    = k_a;
                g1_d    = g_a;
                s1_d    = s_a;
                neg1_d  = negIn;
                ra1_d   = ra;
                exp1_d  = exp_a;
                tiny1_d = tiny_a;
            end
        end
    end

    always_comb begin
        v2_d   = v2_q;
        neg2_d = neg2_q;
        exp2_d = exp2_q;
        sig2_d = sig2_q;
        inx2_d = inx2_q;
        ovf2_d = ovf2_q;
        unf2_d = unf2_q;
        if (a2) begin
            v2_d = v1_q;
            if (v1_q) begin
                neg2_d = neg1_q;
                exp2_d = exp_r;
                sig2_d = sig_r;
                inx2_d = inx_r;
                ovf2_d = ovf_r;
                // Tininess is judged before rounding.
                unf2_d = tiny1_q & inx_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            k1_q    <= '0;
            g1_q    <= 1'b0;
            s1_q    <= 1'b0;
            neg1_q  <= 1'b0;
            ra1_q   <= '0;
            exp1_q  <= '0;
            tiny1_q <= 1'b0;
            v2_q    <= 1'b0;
            neg2_q  <= 1'b0;
            exp2_q  <= '0;
            sig2_q  <= '0;
            inx2_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            unf2_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            k1_q    <= k1_d;
            g1_q    <= g1_d;
            s1_q    <= s1_d;
            neg1_q  <= neg1_d;
            ra1_q   <= ra1_d;
            exp1_q  <= exp1_d;
            tiny1_q <= tiny1_d;
            v2_q    <= v2_d;
            neg2_q  <= neg2_d;
            exp2_q  <= exp2_d;
            sig2_q  <= sig2_d;
            inx2_q  <= inx2_d;
            ovf2_q  <= ovf2_d;
            unf2_q  <= unf2_d;
        end
    end

    assign out_valid = v2_q;
    assign negOut    = neg2_q;
    assign expOut    = exp2_q;
    assign sigOut    = sig2_q;
    assign inexact   = inx2_q;
    assign overflow  = ovf2_q;
    assign underflow = unf2_q;

endmodule

// File: tb/tb_round_pipe.sv
// Directed-vector bench for round_pipe (INTn=32, NEXP=8, NSIG=23).
// Packed result = {valid, neg, exp[9:0], sig[23:0], inexact, overflow, underflow}.
module tb_round_pipe;

    localparam logic [4:0] RNE = 5'b00001;
    localparam logic [4:0] RNA = 5'b00010;
    localparam logic [4:0] RTP = 5'b00100;
    localparam logic [4:0] RTN = 5'b01000;
    localparam logic [4:0] RTZ = 5'b10000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              negIn;
    logic signed [9:0] expIn;
    logic [31:0]       sigIn;
    logic [4:0]        ra;
    logic              out_valid;
    logic              out_ready;
    logic              negOut;
    logic signed [9:0] expOut;
    logic [23:0]       sigOut;
    logic              inexact;
    logic              overflow;
    logic              underflow;

    logic [38:0] cur;
    logic [38:0] got;
    int          got_lat;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    round_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .negIn     (negIn),
        .expIn     (expIn),
        .sigIn     (sigIn),
        .ra        (ra),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .negOut    (negOut),
        .expOut    (expOut),
        .sigOut    (sigOut),
        .inexact   (inexact),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign cur = {out_valid, negOut, expOut, sigOut,
                  inexact, overflow, underflow};

    function automatic logic [38:0] pk(
        input logic v, input logic n, input int e,
        input logic [23:0] s, input logic i, input logic o,
        input logic u);
        return {v, n, 10'(e), s, i, o, u};
    endfunction

    // Push one beat into an idle pipe and capture its output beat.
    task automatic run_one(input logic n, input int e,
                           input logic [31:0] s, input logic [4:0] m);
        @(negedge clk);
        negIn     = n;
        expIn     = 10'(e);
        sigIn     = s;
        ra        = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got       = '0;
        got_lat   = 0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (out_valid) begin
                got     = cur;
                got_lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        negIn     = 1'b0;
        expIn     = '0;
        sigIn     = '0;
        ra        = RNE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cur !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got=%h rdy=%b want=0 rdy=1",
                     cur, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rne();
        logic [38:0] w;
        run_one(0, 0, 32'h80000080, RNE);
        w = pk(1, 0, 0, 24'h800000, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rne_tie_even got=%h want=%h", got, w);
        end
        vectors++;
        if (got_lat !== 2) begin
            miscompares++;
            $display("FAIL latency got=%0d want=2", got_lat);
        end
        run_one(0, 0, 32'h80000180, RNE);
        w = pk(1, 0, 0, 24'h800002, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rne_tie_odd got=%h want=%h", got, w);
        end
    endtask

    task automatic test_overflow();
        logic [38:0] w;
        run_one(0, 127, 32'hFFFFFFFF, RNE);
        w = pk(1, 0, 128, 24'h800000, 1, 1, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ovf_rne_inf got=%h want=%h", got, w);
        end
        run_one(0, 127, 32'hFFFFFFFF, RTZ);
        w = pk(1, 0, 127, 24'hFFFFFF, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtz_maxfin got=%h want=%h", got, w);
        end
        run_one(0, 127, 32'hFFFFFFFF, RTN);
        w = pk(1, 0, 127, 24'hFFFFFF, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtn_pos_maxfin got=%h want=%h", got, w);
        end
        run_one(1, 127, 32'hFFFFFFFF, RTN);
        w = pk(1, 1, 128, 24'h800000, 1, 1, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtn_neg_inf got=%h want=%h", got, w);
        end
        run_one(0, 128, 32'h80000000, RTZ);
        w = pk(1, 0, 127, 24'hFFFFFF, 1, 1, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ovf_rtz_sat got=%h want=%h", got, w);
        end
        run_one(1, 128, 32'h80000000, RTP);
        w = pk(1, 1, 127, 24'hFFFFFF, 1, 1, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ovf_rtp_neg_sat got=%h want=%h", got, w);
        end
        run_one(1, 128, 32'h80000000, RNA);
        w = pk(1, 1, 128, 24'h800000, 1, 1, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ovf_rna_inf got=%h want=%h", got, w);
        end
    endtask

    task automatic test_subnormal();
        logic [38:0] w;
        run_one(0, -127, 32'h80000000, RNE);
        w = pk(1, 0, -126, 24'h400000, 0, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_exact got=%h want=%h", got, w);
        end
        run_one(0, -150, 32'h80000000, RNE);
        w = pk(1, 0, -126, 24'h000000, 1, 0, 1);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_rne_zero got=%h want=%h", got, w);
        end
        run_one(0, -150, 32'h80000000, RTP);
        w = pk(1, 0, -126, 24'h000001, 1, 0, 1);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_rtp_min got=%h want=%h", got, w);
        end
        run_one(0, -200, 32'h80000000, RTP);
        w = pk(1, 0, -126, 24'h000001, 1, 0, 1);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_clamp_rtp got=%h want=%h", got, w);
        end
        run_one(1, -200, 32'h80000000, RNE);
        w = pk(1, 1, -126, 24'h000000, 1, 0, 1);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_clamp_rne got=%h want=%h", got, w);
        end
        run_one(0, -127, 32'hFFFFFFFF, RNE);
        w = pk(1, 0, -126, 24'h800000, 1, 0, 1);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL sub_promote got=%h want=%h", got, w);
        end
        run_one(0, 0, 32'h00000000, RNE);
        w = pk(1, 0, -126, 24'h000000, 0, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL zero_in got=%h want=%h", got, w);
        end
    endtask

    task automatic test_modes();
        logic [38:0] w;
        run_one(0, 0, 32'h80000080, RNA);
        w = pk(1, 0, 0, 24'h800001, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rna_tie got=%h want=%h", got, w);
        end
        run_one(0, 0, 32'h80000080, RTZ);
        w = pk(1, 0, 0, 24'h800000, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtz_trunc got=%h want=%h", got, w);
        end
        run_one(0, 0, 32'h80000080, 5'b00011);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ra_two_hot got=%h want=%h", got, w);
        end
        run_one(0, 0, 32'h80000080, 5'b00000);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL ra_zero got=%h want=%h", got, w);
        end
        run_one(1, 0, 32'h80000001, RTN);
        w = pk(1, 1, 0, 24'h800001, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtn_neg_up got=%h want=%h", got, w);
        end
        run_one(1, 0, 32'h80000001, RTP);
        w = pk(1, 1, 0, 24'h800000, 1, 0, 0);
        vectors++;
        if (got !== w) begin
            miscompares++;
            $display("FAIL rtp_neg_down got=%h want=%h", got, w);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] want_sig [8];
        logic [38:0] held;
        logic        held_v;
        logic        saw_full;
        int          tx;
        int          rx;
        int          cyc;
        held     = '0;
        held_v   = 1'b0;
        saw_full = 1'b0;
        tx       = 0;
        rx       = 0;
        cyc      = 0;
        for (int i = 0; i < 8; i++) want_sig[i] = 24'h800000 + 24'(i * 3);
        while (rx < 8 && cyc < 80) begin
            @(negedge clk);
            if (held_v) begin
                vectors++;
                if (cur !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold got=%h want=%h", cur, held);
                end
            end
            out_ready = !(cyc >= 4 && cyc < 9);
            if (tx < 8) begin
                in_valid = 1'b1;
                negIn    = 1'b0;
                expIn    = '0;
                ra       = RTZ;
                sigIn    = {want_sig[tx], 8'h00};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && !in_ready) saw_full = 1'b1;
            held_v = out_valid && !out_ready;
            held   = cur;
            if (out_valid && out_ready) begin
                vectors++;
                if (sigOut !== want_sig[rx] || expOut !== 10'sd0 ||
                    inexact !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_beat%0d got=%h want=%h",
                             rx, sigOut, want_sig[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (rx !== 8) begin
            miscompares++;
            $display("FAIL bp_count got=%0d want=8", rx);
        end
        vectors++;
        if (saw_full !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_in_ready_drop got=%b want=1", saw_full);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_extra_beat got=%b want=0", out_valid);
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        negIn     = 1'b1;
        expIn     = 10'sd5;
        ra        = RNE;
        sigIn     = 32'hC0000000;
        @(negedge clk);
        sigIn     = 32'hA0000000;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_flush got=v%b r%b want=v0 r1",
                     out_valid, in_ready);
        end
        vectors++;
        if (cur !== '0) begin
            miscompares++;
            $display("FAIL rst_data got=%h want=0", cur);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_ghost got=%b want=0", out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rne();
        test_overflow();
        test_subnormal();
        test_modes();
        test_backpressure();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
